// File: rtl/stdout_sched_pkg.sv
// Shared types and constants for the stdout scheduler: FSM encoding, ASCII
// line-ending codes and a pointer-width helper for the FIFO.
package stdout_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// DEPTH x 8 register FIFO with push/pop, full/empty flags and an occupancy
// count. A push while full is accepted only when a pop frees a slot that cycle.
module sync_fifo
  import stdout_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    wdata,
  output logic [7:0]                    rdata,
  output logic                          full,
  output logic                          empty,
  output logic [ptr_width(DEPTH):0]     count
);

  localparam int PW = ptr_width(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   next_count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == DEPTH[PW:0]);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_count = count;
    if (wr_en && !rd_en) begin
      next_count = count + (PW+1)'(1);
    end else if (rd_en && !wr_en) begin
      next_count = count - (PW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define validity, and a reset-free array maps to plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= next_count;
    end
  end

endmodule

// File: rtl/stdout_sched.sv
// Buffers core stdout strobes in a FIFO and drains them to uart_tx over the
// start/ready handshake. Define STDOUT_CRLF_EN to expand LF into CR LF.
module stdout_sched
  import stdout_sched_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STALL_LEVEL = 14,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           stdout,
  input  logic                 stdout_en,
  output logic                 cpu_en,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_ready,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] sent_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] STALL_CNT = STALL_LEVEL[PW:0];

  state_t      state;
  logic        en_q;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic [PW:0] count;
  logic [PW:0] next_count;

  assign push    = stdout_en && !en_q;
  assign push_ok = push && (!full || pop);

`ifdef STDOUT_CRLF_EN
  logic       pend_valid;
  logic [7:0] pend_data;
  // A held LF takes priority over fresh FIFO bytes.
  assign pop = (state == IDLE) && tx_ready && !empty && !pend_valid;
`else
  assign pop = (state == IDLE) && tx_ready && !empty;
`endif

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (stdout),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Occupancy after this edge; drives the registered stall so the core
  // stops with enough headroom for one strobe already in flight.
  always_comb begin
    next_count = count;
    case ({push_ok, pop})
      2'b10:   next_count = count + (PW+1)'(1);
      2'b01:   next_count = count - (PW+1)'(1);
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      cpu_en   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      en_q   <= stdout_en;
      cpu_en <= (next_count < STALL_CNT);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      sent_count <= '0;
`ifdef STDOUT_CRLF_EN
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef STDOUT_CRLF_EN
          if (pend_valid && tx_ready) begin
            tx_data    <= pend_data;
            pend_valid <= 1'b0;
            tx_start   <= 1'b1;
            state      <= START;
          end else if (pop) begin
            if (head == ASCII_LF) begin
              tx_data    <= ASCII_CR;
              pend_data  <= ASCII_LF;
              pend_valid <= 1'b1;
            end else begin
              tx_data <= head;
            end
            tx_start <= 1'b1;
            state    <= START;
          end
`else
          if (pop) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= START;
          end
`endif
        end
        START: begin
          // uart_tx acknowledges by dropping ready; only then is the byte counted.
          if (!tx_ready) begin
            tx_start   <= 1'b0;
            sent_count <= sent_count + CNT_WIDTH'(1);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (tx_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_sched.sv
// Self-checking bench for stdout_sched: a uart_tx model, an output monitor and
// a byte scoreboard, with one task per scenario.
module tb_stdout_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  stdout;
  logic        stdout_en;
  logic        tx_ready;
  logic        cpu_en;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        overflow;
  logic [15:0] sent_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_rd = 0;
  int         exp_sent = 0;

  logic uart_auto = 1'b1;
  logic manual_ready = 1'b1;
  logic model_ready = 1'b1;
  int   busy_cnt = 0;
  int   busy_len = 4;
  logic start_q = 1'b0;

  stdout_sched dut (
    .clk        (clk),
    .reset      (reset),
    .stdout     (stdout),
    .stdout_en  (stdout_en),
    .cpu_en     (cpu_en),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .overflow   (overflow),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  assign tx_ready = uart_auto ? model_ready : manual_ready;

  // uart_tx model: drops ready the half-cycle after seeing start, stays busy busy_len cycles.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      model_ready <= 1'b1;
      busy_cnt    <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_ready <= 1'b1;
    end else if (tx_start && model_ready) begin
      model_ready <= 1'b0;
      busy_cnt    <= busy_len;
    end
  end

  // Monitor: one entry per rising edge of tx_start.
  always @(negedge clk) begin
    if (tx_start && !start_q) obs_q.push_back(tx_data);
    start_q <= tx_start;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset        = 1'b1;
    stdout_en    = 1'b0;
    stdout       = 8'h00;
    uart_auto    = 1'b1;
    manual_ready = 1'b1;
    busy_len     = 4;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    exp_sent = 0;
    exp_q.delete();
    obs_rd   = obs_q.size();
    @(negedge clk);
  endtask

  task automatic wait_outputs(input int n);
    for (int c = 0; c < 3000; c++) begin
      if (obs_q.size() - obs_rd >= n) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stdout_en = 1'b0;
    stdout = 8'h00;
    repeat (2) @(negedge clk);
    tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL reset_cpu_en: got %b want 1", cpu_en); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests++; if (sent_count !== 16'd0) begin fails++; $display("FAIL reset_sent_count: got %0d want 0", sent_count); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] got, want;
    logic cpu_low = 1'b0;
    apply_reset();
    @(negedge clk);
    stdout = 8'h41; stdout_en = 1'b1;
    exp_q.push_back(8'h41); exp_sent++;
    for (int c = 0; c < 60; c++) begin
      if (c == 5) stdout_en = 1'b0;
      if (cpu_en !== 1'b1) cpu_low = 1'b1;
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      tests++;
      if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL single_missing: got none want %h", want); end
      else begin got = obs_q[obs_rd]; obs_rd++;
        if (got !== want) begin fails++; $display("FAIL single_data: got %h want %h", got, want); end end
    end
    tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL single_extra: got %0d extra starts want 0", obs_q.size() - obs_rd); end
    tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL single_sent: got %0d want %0d", sent_count, exp_sent); end
    tests++; if (cpu_low !== 1'b0) begin fails++; $display("FAIL single_cpu_en: got low want always 1"); end
  endtask

  task automatic test_burst();
    logic [7:0] got, want;
    int occ;
    apply_reset();
    uart_auto = 1'b0; manual_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stdout = 8'(8'h60 + i); stdout_en = 1'b1;
      if (i < 16) exp_q.push_back(8'(8'h60 + i));
      @(negedge clk);
      stdout_en = 1'b0;
      occ = (i + 1 > 16) ? 16 : i + 1;
      // cpu_en is registered from the post-edge occupancy, so it reflects occ right after the push.
      tests++; if (cpu_en !== (occ < 14)) begin fails++; $display("FAIL burst_cpu_en[%0d]: got %b want %b", i, cpu_en, (occ < 14)); end
      tests++; if (overflow !== (i >= 16)) begin fails++; $display("FAIL burst_overflow[%0d]: got %b want %b", i, overflow, (i >= 16)); end
      @(negedge clk);
    end
    uart_auto = 1'b1;
    exp_sent += 16;
    wait_outputs(16);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      tests++;
      if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL burst_missing: got none want %h", want); end
      else begin got = obs_q[obs_rd]; obs_rd++;
        if (got !== want) begin fails++; $display("FAIL burst_data: got %h want %h", got, want); end end
    end
    tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL burst_extra: got %0d extra starts want 0", obs_q.size() - obs_rd); end
    tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL burst_sent: got %0d want %0d", sent_count, exp_sent); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL burst_sticky: got %b want 1", overflow); end
    tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL burst_cpu_en_release: got %b want 1", cpu_en); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] got, want;
    apply_reset();
    uart_auto = 1'b0; manual_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      stdout = 8'(8'h80 + i); stdout_en = 1'b1;
      exp_q.push_back(8'(8'h80 + i));
      @(negedge clk);
      stdout_en = 1'b0;
    end
    @(negedge clk);
    // FIFO full: the push of 0x55 lands on the same edge IDLE pops the head.
    stdout = 8'h55; stdout_en = 1'b1; manual_ready = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clk);
    stdout_en = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_overflow: got %b want 0", overflow); end
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL full_cpu_en: got %b want 0", cpu_en); end
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL full_tx_start: got %b want 1", tx_start); end
    uart_auto = 1'b1;
    exp_sent += 17;
    wait_outputs(17);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      tests++;
      if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL full_missing: got none want %h", want); end
      else begin got = obs_q[obs_rd]; obs_rd++;
        if (got !== want) begin fails++; $display("FAIL full_data: got %h want %h", got, want); end end
    end
    tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL full_extra: got %0d extra starts want 0", obs_q.size() - obs_rd); end
    tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL full_sent: got %0d want %0d", sent_count, exp_sent); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_overflow_end: got %b want 0", overflow); end
  endtask

  task automatic test_handshake_hold();
    logic [7:0] got;
    apply_reset();
    uart_auto = 1'b0; manual_ready = 1'b1;
    @(negedge clk);
    stdout = 8'h33; stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tx_start === 1'b1) break;
      @(negedge clk);
    end
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL hold_start_timeout: got %b want 1", tx_start); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL hold_tx_start[%0d]: got %b want 1", c, tx_start); end
      tests++; if (tx_data !== 8'h33) begin fails++; $display("FAIL hold_tx_data[%0d]: got %h want 33", c, tx_data); end
      tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL hold_sent[%0d]: got %0d want %0d", c, sent_count, exp_sent); end
    end
    manual_ready = 1'b0;
    @(negedge clk);
    exp_sent++;
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL hold_release_start: got %b want 0", tx_start); end
    tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL hold_release_sent: got %0d want %0d", sent_count, exp_sent); end
    tests++; if (tx_data !== 8'h33) begin fails++; $display("FAIL hold_busy_data: got %h want 33", tx_data); end
    manual_ready = 1'b1;
    uart_auto = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() - obs_rd != 1) begin fails++; $display("FAIL hold_starts: got %0d want 1", obs_q.size() - obs_rd); end
    else begin got = obs_q[obs_rd]; obs_rd++;
      if (got !== 8'h33) begin fails++; $display("FAIL hold_obs_data: got %h want 33", got); end end
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    busy_len = 25;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stdout = 8'(8'hA0 + i); stdout_en = 1'b1;
      @(negedge clk);
      stdout_en = 1'b0;
    end
    @(negedge clk);
    tests++; if (tx_ready !== 1'b0 || tx_start !== 1'b0) begin fails++; $display("FAIL mid_busy: got ready=%b start=%b want 0/0", tx_ready, tx_start); end
    tests++; if (sent_count !== 16'd1) begin fails++; $display("FAIL mid_sent_before: got %0d want 1", sent_count); end
    reset = 1'b1;
    #1;
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
    tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL mid_cpu_en: got %b want 1", cpu_en); end
    tests++; if (sent_count !== 16'd0) begin fails++; $display("FAIL mid_sent: got %0d want 0", sent_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
    @(negedge clk);
    reset = 1'b0;
    busy_len = 4;
    exp_sent = 0;
    obs_rd = obs_q.size();
    repeat (40) @(negedge clk);
    tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL mid_fifo_empty: got %0d starts want 0", obs_q.size() - obs_rd); end
    tests++; if (sent_count !== 16'd0) begin fails++; $display("FAIL mid_sent_after: got %0d want 0", sent_count); end
  endtask

  task automatic test_crlf();
    logic [7:0] got, want;
    int n;
    apply_reset();
    @(negedge clk);
    stdout = 8'h41; stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stdout = 8'h0A; stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
    exp_q.push_back(8'h41);
`ifdef STDOUT_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
    n = exp_q.size();
    exp_sent += n;
    wait_outputs(n);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      tests++;
      if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL crlf_missing: got none want %h", want); end
      else begin got = obs_q[obs_rd]; obs_rd++;
        if (got !== want) begin fails++; $display("FAIL crlf_data: got %h want %h", got, want); end end
    end
    tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL crlf_extra: got %0d extra starts want 0", obs_q.size() - obs_rd); end
    tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL crlf_sent: got %0d want %0d", sent_count, exp_sent); end
  endtask

  initial begin
    stdout    = 8'h00;
    stdout_en = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_single_byte();
    test_burst();
    test_full_push_pop();
    test_handshake_hold();
    test_reset_mid_transfer();
    test_crlf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
